// File: rtl/fpnorm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpnorm_pkg
// Description : Shared types and constants for the iterative FP normalizer:
//               FSM state encoding, datapath widths, saturated exponent value
//               and the {sign, exponent, fraction} result bundle.
// Ports       : none (package)
// Config      : FPNORM_FLAGS_EN (used by importing modules only)
// Revision    : 1.0 - initial release
// ============================================================================
package fpnorm_pkg;

   localparam int MANT_W = 24;                  // magnitude width incl. hidden bit
   localparam int EXP_W  = 8;                   // exponent width
   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exponent;
      logic [MANT_W-2:0] fraction;
   } normResult_t;

endpackage
`default_nettype wire

// File: rtl/fp_norm_step.sv
`default_nettype none
// ============================================================================
// Module      : fp_norm_step
// Description : Combinational single-step normalization decision. Given the
//               25-bit work register {carry, magnitude} and the exponent, it
//               either finishes (presenting the packed result) or returns the
//               work/exponent after one left shift.
// Ports       : i_work, i_exponent, i_sign  - current iteration state
//               o_nextWork, o_nextExponent   - state after one left shift
//               o_done                       - result is final this cycle
//               o_result                     - {sign, exponent, fraction}
//               o_overflowCond/o_underflowCond/o_zeroCond (FPNORM_FLAGS_EN)
// Config      : FPNORM_FLAGS_EN adds the flag condition outputs
// Revision    : 1.0 - initial release
// ============================================================================
module fp_norm_step
   import fpnorm_pkg::*;
(
   input  logic [MANT_W:0]   i_work,
   input  logic [EXP_W-1:0]  i_exponent,
   input  logic              i_sign,
   output logic [MANT_W:0]   o_nextWork,
   output logic [EXP_W-1:0]  o_nextExponent,
   output logic              o_done,
   output normResult_t       o_result
`ifdef FPNORM_FLAGS_EN
   ,
   output logic              o_overflowCond,
   output logic              o_underflowCond,
   output logic              o_zeroCond
`endif
);

   logic [EXP_W-1:0] w_expInc;

   assign w_expInc = i_exponent + 1'b1;

   always_comb begin
      o_nextWork     = i_work;
      o_nextExponent = i_exponent;
      o_done         = 1'b0;
      // Default bundle covers the Inf/NaN pass-through and already-normal cases
      o_result.sign     = i_sign;
      o_result.exponent = i_exponent;
      o_result.fraction = i_work[MANT_W-2:0];
`ifdef FPNORM_FLAGS_EN
      o_overflowCond  = 1'b0;
      o_underflowCond = 1'b0;
      o_zeroCond      = 1'b0;
`endif
      if (i_exponent == EXP_MAX) begin
         o_done = 1'b1;
      end else if (i_work == '0) begin
         // Exact zero is always reported as +0
         o_done   = 1'b1;
         o_result = '0;
`ifdef FPNORM_FLAGS_EN
         o_zeroCond = 1'b1;
`endif
      end else if (i_work[MANT_W]) begin
         // Carry out: a single right shift always restores bit 23
         o_done            = 1'b1;
         o_result.exponent = w_expInc;
         if (w_expInc == EXP_MAX) begin
            o_result.fraction = '0;
`ifdef FPNORM_FLAGS_EN
            o_overflowCond = 1'b1;
`endif
         end else begin
            o_result.fraction = i_work[MANT_W-1:1];
         end
      end else if (i_work[MANT_W-1]) begin
         o_done = 1'b1;
      end else if (i_exponent <= EXP_W'(1)) begin
         // Cannot shift further without going below the minimum exponent
         o_done            = 1'b1;
         o_result.exponent = '0;
`ifdef FPNORM_FLAGS_EN
         o_underflowCond = 1'b1;
`endif
      end else begin
         o_nextWork     = i_work << 1;
         o_nextExponent = i_exponent - 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fp_normalize_seq.sv
`default_nettype none
// ============================================================================
// Module      : fp_normalize_seq
// Description : Iterative normalizer for the single-precision adder. Latches
//               the ALU magnitude/carry, sign and common exponent, shifts one
//               bit per clock until the hidden bit reaches bit 23, then holds
//               sign/exponent/fraction for the pack stage (valid/ready).
// Ports       : clk, rst_n (async, active-low)
//               inValid/inReady, alignedResult, carryOut, alignedSign,
//               exponentOut                          - upstream operand
//               outValid/outReady, normalizedSign, normalizedExponent,
//               normalizedMantissa                   - downstream result
//               overflowFlag, underflowFlag, zeroFlag (FPNORM_FLAGS_EN)
// Config      : FPNORM_FLAGS_EN adds the status flag ports and registers
// Revision    : 1.0 - initial release
// ============================================================================
module fp_normalize_seq #(
   parameter int MANT_W = 24,
   parameter int EXP_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inValid,
   output logic              inReady,
   input  logic [MANT_W-1:0] alignedResult,
   input  logic              carryOut,
   input  logic              alignedSign,
   input  logic [EXP_W-1:0]  exponentOut,
   output logic              outValid,
   input  logic              outReady,
   output logic              normalizedSign,
   output logic [EXP_W-1:0]  normalizedExponent,
   output logic [MANT_W-2:0] normalizedMantissa
`ifdef FPNORM_FLAGS_EN
   ,
   output logic              overflowFlag,
   output logic              underflowFlag,
   output logic              zeroFlag
`endif
);
   import fpnorm_pkg::*;

   state_t           r_state;
   logic [MANT_W:0]  r_work;
   logic [EXP_W-1:0] r_exp;
   logic             r_sign;
   logic             r_inReady;
   logic             r_outValid;
   normResult_t      r_result;

   logic [MANT_W:0]  w_nextWork;
   logic [EXP_W-1:0] w_nextExp;
   logic             w_done;
   normResult_t      w_result;

`ifdef FPNORM_FLAGS_EN
   logic r_overflow, r_underflow, r_zero;
   logic w_overflowCond, w_underflowCond, w_zeroCond;
`endif

   fp_norm_step u_step (
      .i_work          (r_work),
      .i_exponent      (r_exp),
      .i_sign          (r_sign),
      .o_nextWork      (w_nextWork),
      .o_nextExponent  (w_nextExp),
      .o_done          (w_done),
      .o_result        (w_result)
`ifdef FPNORM_FLAGS_EN
      ,
      .o_overflowCond  (w_overflowCond),
      .o_underflowCond (w_underflowCond),
      .o_zeroCond      (w_zeroCond)
`endif
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_work     <= '0;
         r_exp      <= '0;
         r_sign     <= 1'b0;
         r_inReady  <= 1'b1;
         r_outValid <= 1'b0;
         r_result   <= '0;
`ifdef FPNORM_FLAGS_EN
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_zero      <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (inValid) begin
                  r_work    <= {carryOut, alignedResult};
                  r_exp     <= exponentOut;
                  r_sign    <= alignedSign;
                  r_inReady <= 1'b0;
                  r_state   <= SHIFT;
               end
            end
            SHIFT: begin
               if (w_done) begin
                  r_result   <= w_result;
                  r_outValid <= 1'b1;
`ifdef FPNORM_FLAGS_EN
                  r_overflow  <= w_overflowCond;
                  r_underflow <= w_underflowCond;
                  r_zero      <= w_zeroCond;
`endif
                  r_state    <= DONE;
               end else begin
                  r_work <= w_nextWork;
                  r_exp  <= w_nextExp;
               end
            end
            DONE: begin
               // Result registers stay put; only flags are cleared on accept
               if (outReady) begin
                  r_outValid <= 1'b0;
                  r_inReady  <= 1'b1;
`ifdef FPNORM_FLAGS_EN
                  r_overflow  <= 1'b0;
                  r_underflow <= 1'b0;
                  r_zero      <= 1'b0;
`endif
                  r_state    <= IDLE;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_inReady  <= 1'b1;
               r_outValid <= 1'b0;
            end
         endcase
      end
   end

   assign inReady            = r_inReady;
   assign outValid           = r_outValid;
   assign normalizedSign     = r_result.sign;
   assign normalizedExponent = r_result.exponent;
   assign normalizedMantissa = r_result.fraction;
`ifdef FPNORM_FLAGS_EN
   assign overflowFlag  = r_overflow;
   assign underflowFlag = r_underflow;
   assign zeroFlag      = r_zero;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_normalize_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_normalize_seq
// Description : Scoreboard bench for fp_normalize_seq. A driver issues
//               directed operands and queues hand-computed results; a monitor
//               pops and compares whenever outValid is presented, and checks
//               the outputs stay stable under backpressure.
// Config      : FPNORM_FLAGS_EN enables flag port connections and checks
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_normalize_seq;

   logic        clk;
   logic        rst_n;
   logic        inValid;
   logic        inReady;
   logic [23:0] alignedResult;
   logic        carryOut;
   logic        alignedSign;
   logic [7:0]  exponentOut;
   logic        outValid;
   logic        outReady;
   logic        normalizedSign;
   logic [7:0]  normalizedExponent;
   logic [22:0] normalizedMantissa;
`ifdef FPNORM_FLAGS_EN
   logic        overflowFlag, underflowFlag, zeroFlag;
`endif

   fp_normalize_seq u_dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .inValid            (inValid),
      .inReady            (inReady),
      .alignedResult      (alignedResult),
      .carryOut           (carryOut),
      .alignedSign        (alignedSign),
      .exponentOut        (exponentOut),
      .outValid           (outValid),
      .outReady           (outReady),
      .normalizedSign     (normalizedSign),
      .normalizedExponent (normalizedExponent),
      .normalizedMantissa (normalizedMantissa)
`ifdef FPNORM_FLAGS_EN
      ,
      .overflowFlag       (overflowFlag),
      .underflowFlag      (underflowFlag),
      .zeroFlag           (zeroFlag)
`endif
   );

   typedef struct {
      logic        s;
      logic [7:0]  e;
      logic [22:0] f;
      logic        ovf;
      logic        unf;
      logic        zro;
      int          lat;
      int          acceptCyc;
   } expect_t;

   expect_t sb[$];
   expect_t cur;
   int      checks = 0;
   int      fails  = 0;
   int      cyc    = 0;
   bit      seenValid = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic expect_t mk(input logic s, input logic [7:0] e, input logic [22:0] f,
                                  input logic ovf, input logic unf, input logic zro,
                                  input int lat);
      expect_t x;
      x.s = s; x.e = e; x.f = f; x.ovf = ovf; x.unf = unf; x.zro = zro;
      x.lat = lat; x.acceptCyc = 0;
      return x;
   endfunction

   // Drive one operand, wait (bounded) for acceptance, optionally queue its result
   task automatic issue(input logic [23:0] a, input logic c, input logic s,
                        input logic [7:0] e, input expect_t x, input bit push);
      int guard = 0;
      @(negedge clk);
      while (!inReady && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!inReady) begin
         checks++;
         fails++;
         $display("FAIL accept_timeout: inReady=0 expected 1 within 100 cycles");
         return;
      end
      alignedResult = a;
      carryOut      = c;
      alignedSign   = s;
      exponentOut   = e;
      inValid       = 1'b1;
      @(posedge clk);
      #1;
      inValid     = 1'b0;
      x.acceptCyc = cyc;
      if (push) sb.push_back(x);
   endtask

   task automatic drain();
      int guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while ((sb.size() != 0 || outValid) && guard < 200);
      if (sb.size() != 0 || outValid) begin
         checks++;
         fails++;
         $display("FAIL drain_timeout: pending=%0d outValid=%0b expected 0/0", sb.size(), outValid);
      end
   endtask

   // Monitor: compare on first valid cycle, then check hold stability
   always @(negedge clk) begin
      if (rst_n && outValid) begin
         if (!seenValid) begin
            seenValid = 1'b1;
            if (sb.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_output: outValid=1 expected no result pending");
            end else begin
               cur = sb.pop_front();
               chk("latency",  cyc - cur.acceptCyc, cur.lat);
               chk("sign",     normalizedSign,      cur.s);
               chk("exponent", normalizedExponent,  cur.e);
               chk("fraction", normalizedMantissa,  cur.f);
`ifdef FPNORM_FLAGS_EN
               chk("overflowFlag",  overflowFlag,  cur.ovf);
               chk("underflowFlag", underflowFlag, cur.unf);
               chk("zeroFlag",      zeroFlag,      cur.zro);
`endif
            end
         end else begin
            chk("hold_sign",     normalizedSign,     cur.s);
            chk("hold_exponent", normalizedExponent, cur.e);
            chk("hold_fraction", normalizedMantissa, cur.f);
`ifdef FPNORM_FLAGS_EN
            chk("hold_overflowFlag", overflowFlag, cur.ovf);
`endif
         end
         chk("inReady_while_valid", inReady, 1'b0);
         if (outReady) seenValid = 1'b0;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int guard;
      rst_n = 1'b0; inValid = 1'b0; alignedResult = '0; carryOut = 1'b0;
      alignedSign = 1'b0; exponentOut = '0; outReady = 1'b1;
      repeat (3) @(negedge clk);

      chk("reset_inReady",  inReady,            1'b1);
      chk("reset_outValid", outValid,           1'b0);
      chk("reset_sign",     normalizedSign,     1'b0);
      chk("reset_exponent", normalizedExponent, 8'h00);
      chk("reset_fraction", normalizedMantissa, 23'h0);
`ifdef FPNORM_FLAGS_EN
      chk("reset_flags", {overflowFlag, underflowFlag, zeroFlag}, 3'b000);
`endif
      rst_n = 1'b1;

      // operand                    carry sign exp      expected s  e      f         ovf unf zro lat
      issue(24'h800000, 1'b0, 1'b0, 8'h7F, mk(1'b0, 8'h7F, 23'h000000, 0, 0, 0, 1),  1'b1);
      issue(24'h000000, 1'b1, 1'b0, 8'h7F, mk(1'b0, 8'h80, 23'h000000, 0, 0, 0, 1),  1'b1);
      issue(24'h000001, 1'b0, 1'b0, 8'h7F, mk(1'b0, 8'h68, 23'h000000, 0, 0, 0, 24), 1'b1);
      issue(24'h000000, 1'b0, 1'b1, 8'h40, mk(1'b0, 8'h00, 23'h000000, 0, 0, 1, 1),  1'b1);
      issue(24'h000100, 1'b0, 1'b1, 8'h03, mk(1'b1, 8'h00, 23'h000400, 0, 1, 0, 3),  1'b1);
      issue(24'h400001, 1'b0, 1'b1, 8'hFF, mk(1'b1, 8'hFF, 23'h400001, 0, 0, 0, 1),  1'b1);
      issue(24'h400002, 1'b1, 1'b0, 8'h10, mk(1'b0, 8'h11, 23'h200001, 0, 0, 0, 1),  1'b1);
      issue(24'h0C0000, 1'b0, 1'b1, 8'h85, mk(1'b1, 8'h81, 23'h400000, 0, 0, 0, 5),  1'b1);
      issue(24'h400000, 1'b0, 1'b0, 8'h01, mk(1'b0, 8'h00, 23'h400000, 0, 1, 0, 1),  1'b1);
      issue(24'h400000, 1'b0, 1'b0, 8'h02, mk(1'b0, 8'h01, 23'h000000, 0, 0, 0, 2),  1'b1);
      drain();

      // Overflow under backpressure
      @(posedge clk);
      #1 outReady = 1'b0;
      issue(24'h123456, 1'b1, 1'b0, 8'hFE, mk(1'b0, 8'hFF, 23'h000000, 1, 0, 0, 1), 1'b1);
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!outValid && guard < 50);
      chk("ovf_outValid_seen", outValid, 1'b1);
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1 outReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("ovf_idle_inReady",  inReady,  1'b1);
      chk("ovf_idle_outValid", outValid, 1'b0);
`ifdef FPNORM_FLAGS_EN
      chk("ovf_flag_cleared", overflowFlag, 1'b0);
`endif
      drain();

      // Reset in the middle of a long shift sequence
      issue(24'h000001, 1'b0, 1'b0, 8'h7F, mk(1'b0, 8'h00, 23'h0, 0, 0, 0, 0), 1'b0);
      repeat (10) @(negedge clk);
      #1 rst_n = 1'b0;
      #2;
      chk("abort_outValid", outValid, 1'b0);
      chk("abort_inReady",  inReady,  1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("post_abort_inReady",  inReady,  1'b1);
      chk("post_abort_outValid", outValid, 1'b0);

      issue(24'h800000, 1'b0, 1'b0, 8'h7F, mk(1'b0, 8'h7F, 23'h000000, 0, 0, 0, 1), 1'b1);
      drain();
      chk("scoreboard_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fp_normalize_seq.md
# fp_normalize_seq

Iterative normalizer for the single-precision adder datapath, sitting directly downstream of the ALU stage and upstream of the pack stage. It accepts the ALU's 24-bit aligned magnitude, carry, sign and the common exponent from the align stage. It shifts the magnitude one bit per clock until the hidden bit sits at bit 23, adjusting the exponent, and then presents sign, exponent and 23-bit fraction to pack. This sequential implementation replaces a single-cycle priority-encoder/barrel-shifter normalizer and uses a valid/ready handshake on both sides.

## Interface
Parameters:
- MANT_W, 24, aligned magnitude width including hidden bit
- EXP_W, 8, exponent width

Ports:
- clk, input, 1, single clock, rising edge
- rst_n, input, 1, asynchronous active-low reset
- inValid, input, 1, upstream operand valid
- inReady, output, 1, block can accept (high only in IDLE)
- alignedResult, input, 24, ALU magnitude, hidden bit at bit 23
- carryOut, input, 1, ALU carry (magnitude bit 24)
- alignedSign, input, 1, result sign from ALU
- exponentOut, input, 8, common exponent from align stage
- outValid, output, 1, normalized result valid
- outReady, input, 1, pack stage accepts
- normalizedSign, output, 1, result sign
- normalizedExponent, output, 8, result exponent
- normalizedMantissa, output, 23, result fraction (hidden bit dropped)
- overflowFlag, underflowFlag, zeroFlag, output, 1 each, present only with FPNORM_FLAGS_EN

Reset is asynchronous and active-low, on rst_n, with clock clk.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: inReady=1. When inValid is high, latch the following and go to SHIFT:
  - 25-bit work register {carryOut, alignedResult}.
  - exponentOut and alignedSign.
- SHIFT evaluates one priority step per cycle:
  1. Latched exponent == 8'hFF (Inf/NaN): pass through with exp 8'hFF and fraction = work[22:0]; go to DONE.
  2. work == 0: output sign 0, exp 0, fraction 0; set zeroFlag; go to DONE.
  3. work[24]=1: right-shift 1 and exp+1.
     - If the new exponent is 8'hFF, force the fraction to 0 and set overflowFlag.
     - Go to DONE.
  4. work[23]=1: go to DONE.
  5. exp <= 1: the value is subnormal. Output exp 0 and fraction = work[22:0]; set underflowFlag; go to DONE.
  6. Otherwise left-shift 1 and exp-1; stay in SHIFT.
- DONE: outValid=1, and outputs hold stable while outReady=0. On outReady=1, go to IDLE.
- inReady is low in SHIFT and DONE. There is no back-to-back accept in the DONE cycle.
- All exponent arithmetic is unsigned 8-bit. Underflow is prevented by rule 5, and overflow saturates at 8'hFF via rule 3.

## Timing
- Reset values:
  - State: IDLE.
  - inReady=1, outValid=0.
  - normalizedSign, normalizedExponent, normalizedMantissa all 0.
  - All flags 0.
- Latency: outValid rises k+1 rising edges after the accepting edge, where k is the number of left shifts (0..23). The worst case is 24 edges.
- Flags are valid only while outValid=1 and clear on the accept edge.
- rst_n asserted in SHIFT or DONE aborts the operation immediately. No result is emitted, and the block returns to IDLE.
- An inValid pulse while inReady=0 is ignored. Upstream must hold inValid until it sees inReady.

## Configuration
- FPNORM_FLAGS_EN defined: overflowFlag, underflowFlag and zeroFlag ports and their registers exist, driven as above.
- FPNORM_FLAGS_EN undefined: the ports and registers are absent. Datapath behaviour is identical.

## Structure
- Package fpnorm_pkg holds:
  - The state enum (IDLE, SHIFT, DONE).
  - The MANT_W and EXP_W constants.
  - EXP_MAX = 8'hFF.
  - A packed struct for the {sign, exponent, fraction} output bundle.
- Sub-module fp_norm_step is a combinational single-step decision block. It takes the work register and exponent and returns the next work register, next exponent, a done indication and flag conditions. The top module holds the FSM and registers.

## Test plan
- Already normal: alignedResult=24'h800000, carry=0, exp=8'h7F, sign=0 -> exp 8'h7F, fraction 0, outValid 1 edge after accept.
- Carry (1.0+1.0): carry=1, alignedResult=0, exp=8'h7F -> exp 8'h80, fraction 0, latency 1.
- Max left shift: alignedResult=24'h000001, exp=8'h7F -> exp 8'h68, fraction 0, outValid 24 edges after accept.
- Zero and subnormal cases:
  - Zero: alignedResult=0, carry=0, sign=1 -> sign 0, exp 0, fraction 0, zeroFlag=1.
  - Subnormal: alignedResult=24'h000100, exp=8'h03 -> exp 0, fraction 23'h000400, underflowFlag=1.
- Overflow and backpressure: carry=1, exp=8'hFE with outReady held low 5 cycles -> exp 8'hFF, fraction 0, overflowFlag=1. Outputs are stable and inReady=0 throughout; the block returns to IDLE one edge after outReady=1.
- Reset mid-shift: alignedResult=24'h000001 accepted, rst_n pulsed low at shift 10 -> outValid never asserts, inReady=1, and a subsequent 24'h800000 operand completes normally.
